// File: rtl/qch_pkg.sv
// Shared types and default timing parameters for the Q-Channel device responder.
package qch_pkg;

    typedef enum logic [2:0] {
        Q_RUN,
        Q_REQUEST,
        Q_STOPPED,
        Q_EXIT,
        Q_DENIED,
        Q_CONTINUE
    } qch_dev_state_t;

    localparam int QCH_IDLE_CYCLES  = 4;
    localparam int QCH_DENY_TIMEOUT = 16;
    localparam int QCH_EXIT_CYCLES  = 2;

    // Counter width large enough to hold the largest of the three cycle limits.
    function automatic int qch_cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/qch_sync2.sv
// Two-flop synchroniser with synchronous reset to a configurable value.
module qch_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/qch_device_responder.sv
// Device-side Q-Channel responder: quiesces the device, accepts or denies the
// low-power request, and gates the device clock while stopped.
module qch_device_responder
    import qch_pkg::*;
#(
    parameter int IDLE_CYCLES  = QCH_IDLE_CYCLES,
    parameter int DENY_TIMEOUT = QCH_DENY_TIMEOUT,
    parameter int EXIT_CYCLES  = QCH_EXIT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic qreqn_i,
    input  logic dev_busy_i,
    input  logic wake_req_i,
    input  logic deny_req_i,
    output logic qacceptn_o,
    output logic qdeny_o,
    output logic qactive_o,
    output logic dev_quiesce_o,
    output logic dev_clk_en_o,
    output logic proto_err_o
);

    localparam int CNT_W = qch_cnt_width(IDLE_CYCLES, DENY_TIMEOUT, EXIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(DENY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] EX_LAST   = CNT_W'(EXIT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    qch_dev_state_t   state;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] ex_cnt;
    logic             qreqn_s;
    logic             qreqn_q;
    logic             qreqn_rise;
    logic             qreqn_fall;

    qch_sync2 #(.RESET_VAL(1'b1)) u_qreqn_sync (
        .clock (clock),
        .reset (reset),
        .d     (qreqn_i),
        .q     (qreqn_s)
    );

    assign qreqn_rise = qreqn_s & ~qreqn_q;
    assign qreqn_fall = ~qreqn_s & qreqn_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= Q_RUN;
            qacceptn_o    <= 1'b1;
            qdeny_o       <= 1'b0;
            qactive_o     <= 1'b0;
            dev_quiesce_o <= 1'b0;
            dev_clk_en_o  <= 1'b1;
            proto_err_o   <= 1'b0;
            idle_cnt      <= '0;
            to_cnt        <= '0;
            ex_cnt        <= '0;
            qreqn_q       <= 1'b1;
        end else begin
            qreqn_q     <= qreqn_s;
            qactive_o   <= dev_busy_i | wake_req_i;
            proto_err_o <= 1'b0;
            unique case (state)
                Q_RUN: begin
                    if (!qreqn_s) begin
                        state         <= Q_REQUEST;
                        dev_quiesce_o <= 1'b1;
                        idle_cnt      <= '0;
                        to_cnt        <= '0;
                        ex_cnt        <= '0;
                    end
                end
                Q_REQUEST: begin
                    proto_err_o <= qreqn_rise;
                    idle_cnt    <= dev_busy_i ? '0 : sat_inc(idle_cnt);
                    to_cnt      <= sat_inc(to_cnt);
                    // Explicit deny outranks accept, which outranks timeout.
                    if (deny_req_i) begin
                        state   <= Q_DENIED;
                        qdeny_o <= 1'b1;
                    end else if (!dev_busy_i && idle_cnt == IDLE_LAST) begin
                        state        <= Q_STOPPED;
                        qacceptn_o   <= 1'b0;
                        dev_clk_en_o <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state   <= Q_DENIED;
                        qdeny_o <= 1'b1;
                    end
                end
                Q_STOPPED: begin
                    if (qreqn_s) begin
                        state        <= Q_EXIT;
                        dev_clk_en_o <= 1'b1;
                        idle_cnt     <= '0;
                        to_cnt       <= '0;
                        ex_cnt       <= '0;
                    end
                end
                Q_EXIT: begin
                    proto_err_o <= qreqn_fall;
                    if (ex_cnt == EX_LAST) begin
                        state         <= Q_RUN;
                        qacceptn_o    <= 1'b1;
                        dev_quiesce_o <= 1'b0;
                    end else begin
                        ex_cnt <= sat_inc(ex_cnt);
                    end
                end
                Q_DENIED: begin
                    if (qreqn_s) begin
                        state   <= Q_CONTINUE;
                        qdeny_o <= 1'b0;
                    end
                end
                Q_CONTINUE: begin
                    proto_err_o   <= qreqn_fall;
                    state         <= Q_RUN;
                    dev_quiesce_o <= 1'b0;
                end
                default: begin
                    state <= Q_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qch_device_responder.sv
// Scoreboard bench for qch_device_responder: directed handshakes with hand-timed output events.
module tb_qch_device_responder;

    logic clock = 1'b0;
    logic reset;
    logic qreqn_i, dev_busy_i, wake_req_i, deny_req_i;
    logic qacceptn_o, qdeny_o, qactive_o, dev_quiesce_o, dev_clk_en_o, proto_err_o;
    logic [5:0] outs;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    qch_device_responder dut (
        .clock         (clock),
        .reset         (reset),
        .qreqn_i       (qreqn_i),
        .dev_busy_i    (dev_busy_i),
        .wake_req_i    (wake_req_i),
        .deny_req_i    (deny_req_i),
        .qacceptn_o    (qacceptn_o),
        .qdeny_o       (qdeny_o),
        .qactive_o     (qactive_o),
        .dev_quiesce_o (dev_quiesce_o),
        .dev_clk_en_o  (dev_clk_en_o),
        .proto_err_o   (proto_err_o)
    );

    assign outs = {qacceptn_o, qdeny_o, qactive_o, dev_quiesce_o, dev_clk_en_o, proto_err_o};

    // Expected output vector after edge t: {qacceptn, qdeny, qactive, quiesce, clk_en, proto_err}.
    task automatic ev(input int t, input logic a, input logic d, input logic ac,
                      input logic q, input logic ce, input logic pe);
        exp_t e;
        e.cyc = t;
        e.v   = {a, d, ac, q, ce, pe};
        sb.push_back(e);
    endtask

    // Returns at the falling edge after posedge t; inputs set then are sampled at edge t+1.
    task automatic step_to(input int t);
        do @(negedge clock); while (cyc < t);
    endtask

    initial begin : monitor
        logic [5:0] prev;
        exp_t e;
        prev = 'x;
        forever begin
            @(negedge clock);
            if (cyc >= 3 && outs !== prev) begin
                prev = outs;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: outputs %b at cycle %0d, no event expected", outs, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.v !== outs || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                                 outs, cyc, e.v, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; qreqn_i = 1'b1; dev_busy_i = 1'b0; wake_req_i = 1'b0; deny_req_i = 1'b0;
        ev(3, 1, 0, 0, 0, 1, 0);
        step_to(3);
        reset = 1'b0;

        // Accept with an idle device
        step_to(9);
        qreqn_i = 1'b0;
        ev(12, 1, 0, 0, 1, 1, 0);
        ev(16, 0, 0, 0, 1, 0, 0);

        // Wake while stopped, then exit
        step_to(19); wake_req_i = 1'b1;
        ev(20, 0, 0, 1, 1, 0, 0);
        step_to(21); wake_req_i = 1'b0;
        ev(22, 0, 0, 0, 1, 0, 0);
        step_to(24); qreqn_i = 1'b1;
        ev(27, 0, 0, 0, 1, 1, 0);
        ev(29, 1, 0, 0, 0, 1, 0);

        // Busy burst restarts the idle count
        step_to(34); qreqn_i = 1'b0;
        ev(37, 1, 0, 0, 1, 1, 0);
        step_to(39); dev_busy_i = 1'b1;
        ev(40, 1, 0, 1, 1, 1, 0);
        step_to(41); dev_busy_i = 1'b0;
        ev(42, 1, 0, 0, 1, 1, 0);
        ev(45, 0, 0, 0, 1, 0, 0);
        step_to(49); qreqn_i = 1'b1;
        ev(52, 0, 0, 0, 1, 1, 0);
        ev(54, 1, 0, 0, 0, 1, 0);

        // Timeout deny with a permanently busy device
        step_to(59); qreqn_i = 1'b0; dev_busy_i = 1'b1;
        ev(60, 1, 0, 1, 0, 1, 0);
        ev(62, 1, 0, 1, 1, 1, 0);
        ev(78, 1, 1, 1, 1, 1, 0);
        step_to(81); qreqn_i = 1'b1; dev_busy_i = 1'b0;
        ev(82, 1, 1, 0, 1, 1, 0);
        ev(84, 1, 0, 0, 1, 1, 0);
        ev(85, 1, 0, 0, 0, 1, 0);

        // Explicit deny on the cycle the idle count completes
        step_to(89); qreqn_i = 1'b0;
        ev(92, 1, 0, 0, 1, 1, 0);
        step_to(95); deny_req_i = 1'b1;
        ev(96, 1, 1, 0, 1, 1, 0);
        step_to(96); deny_req_i = 1'b0;
        step_to(99); qreqn_i = 1'b1;
        ev(102, 1, 0, 0, 1, 1, 0);
        ev(103, 1, 0, 0, 0, 1, 0);

        // Controller withdraws the request mid-handshake
        step_to(109); qreqn_i = 1'b0; dev_busy_i = 1'b1;
        ev(110, 1, 0, 1, 0, 1, 0);
        ev(112, 1, 0, 1, 1, 1, 0);
        step_to(113); qreqn_i = 1'b1;
        ev(116, 1, 0, 1, 1, 1, 1);
        ev(117, 1, 0, 1, 1, 1, 0);
        ev(128, 1, 1, 1, 1, 1, 0);
        ev(129, 1, 0, 1, 1, 1, 0);
        ev(130, 1, 0, 1, 0, 1, 0);
        step_to(131); dev_busy_i = 1'b0;
        ev(132, 1, 0, 0, 0, 1, 0);

        // Reset while stopped with a wake pending
        step_to(134); qreqn_i = 1'b0;
        ev(137, 1, 0, 0, 1, 1, 0);
        ev(141, 0, 0, 0, 1, 0, 0);
        step_to(142); wake_req_i = 1'b1;
        ev(143, 0, 0, 1, 1, 0, 0);
        step_to(144); reset = 1'b1;
        ev(145, 1, 0, 0, 0, 1, 0);
        step_to(145); reset = 1'b0; wake_req_i = 1'b0; qreqn_i = 1'b1;

        step_to(155);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: never observed, required %b at cycle %0d", e.v, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
